// File: rtl/te_port_arbiter.sv
// te_port_arbiter: shares the single port of the text-editor character BRAM
// between the terminal grid-write stream (writer) and a sequential reader.
// The writer normally has priority. A reader that is denied MAX_WAIT cycles in
// a row is forced through on its next request cycle.
// All memory-side signals are registered. Read tags travel alongside the BRAM
// pipeline, so each returned byte is strobed valid exactly when it lands.
// Optional feature: define TE_ARB_STATS_EN to add saturating activity counters.
//
// state        | meaning
// ST_WR_PRI    | writer wins simultaneous requests (reset state)
// ST_RD_FORCED | reader was starved; reader wins simultaneous requests
module te_port_arbiter #(
  parameter int SCREEN_WIDTH  = 76,
  parameter int SCREEN_HEIGHT = 256,
  parameter int ADDR_W        = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT),
  parameter int READ_LATENCY  = 2,
  parameter int MAX_WAIT      = 4
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic              wr_valid_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [7:0]        wr_data_in,
  output logic              wr_ready_out,
  input  logic              rd_valid_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  output logic              rd_ready_out,
  output logic [7:0]        rd_data_out,
  output logic              rd_data_valid_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [7:0]        mem_din_out,
  input  logic [7:0]        mem_dout_in
`ifdef TE_ARB_STATS_EN
  ,
  output logic [15:0]       wr_count_out,
  output logic [15:0]       rd_count_out,
  output logic [15:0]       forced_count_out
`endif
);

  localparam logic [0:0] ST_WR_PRI    = 1'b0;
  localparam logic [0:0] ST_RD_FORCED = 1'b1;

  localparam logic [ADDR_W:0] DEPTH      = (ADDR_W+1)'(SCREEN_WIDTH*SCREEN_HEIGHT);
  localparam logic [3:0]      WAIT_LIMIT = 4'(MAX_WAIT-1);

  logic [0:0] state;
  logic [3:0] wait_cnt;
  logic       wr_acc;
  logic       rd_acc;
  logic       wr_in_range;
  logic       rd_in_range;

  // Index 0 lines up with the registered BRAM address; the remaining
  // READ_LATENCY stages cover the BRAM's own pipeline.
  logic [READ_LATENCY:0] tag_v;
  logic [READ_LATENCY:0] tag_oor;

  // Grant decode: priority flips to the reader only while in ST_RD_FORCED.
  always_comb begin
    wr_ready_out = 1'b0;
    rd_ready_out = 1'b0;
    if (state == ST_RD_FORCED) begin
      rd_ready_out = rd_valid_in;
      wr_ready_out = wr_valid_in & ~rd_valid_in;
    end else begin
      wr_ready_out = wr_valid_in;
      rd_ready_out = rd_valid_in & ~wr_valid_in;
    end
  end

  assign wr_acc      = wr_valid_in & wr_ready_out;
  assign rd_acc      = rd_valid_in & rd_ready_out;
  assign wr_in_range = {1'b0, wr_addr_in} < DEPTH;
  assign rd_in_range = {1'b0, rd_addr_in} < DEPTH;

  // Priority FSM: force one read through after MAX_WAIT denials.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= ST_WR_PRI;
    end else begin
      case (state)
        ST_WR_PRI: begin
          if (rd_valid_in && !rd_acc && wait_cnt == WAIT_LIMIT)
            state <= ST_RD_FORCED;
        end
        default: begin
          if (rd_acc || !rd_valid_in)
            state <= ST_WR_PRI;
        end
      endcase
    end
  end

  // Consecutive-denial counter for a pending read.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in)
      wait_cnt <= 4'd0;
    else if (rd_valid_in && !rd_acc)
      wait_cnt <= wait_cnt + 4'd1;
    else
      wait_cnt <= 4'd0;
  end

  // Registered BRAM port; an out-of-range write still takes the slot but never strobes we.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_we_out   <= 1'b0;
      mem_addr_out <= '0;
      mem_din_out  <= 8'h00;
    end else if (wr_acc) begin
      mem_we_out   <= wr_in_range;
      mem_addr_out <= wr_addr_in;
      mem_din_out  <= wr_data_in;
    end else if (rd_acc) begin
      mem_we_out   <= 1'b0;
      mem_addr_out <= rd_addr_in;
    end else begin
      mem_we_out   <= 1'b0;
    end
  end

  // In-flight read tags; reset drops every outstanding read.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      tag_v   <= '0;
      tag_oor <= '0;
    end else begin
      tag_v   <= {tag_v[READ_LATENCY-1:0], rd_acc};
      tag_oor <= {tag_oor[READ_LATENCY-1:0], rd_acc & ~rd_in_range};
    end
  end

  // Capture returned byte when its tag reaches the end of the pipe.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_data_out       <= 8'h00;
      rd_data_valid_out <= 1'b0;
    end else begin
      rd_data_valid_out <= tag_v[READ_LATENCY];
      if (tag_v[READ_LATENCY])
        rd_data_out <= tag_oor[READ_LATENCY] ? 8'h00 : mem_dout_in;
    end
  end

`ifdef TE_ARB_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_count_out     <= 16'h0000;
      rd_count_out     <= 16'h0000;
      forced_count_out <= 16'h0000;
    end else begin
      if (wr_acc && wr_in_range && wr_count_out != 16'hFFFF)
        wr_count_out <= wr_count_out + 16'd1;
      if (rd_acc && rd_count_out != 16'hFFFF)
        rd_count_out <= rd_count_out + 16'd1;
      if (rd_acc && state == ST_RD_FORCED && forced_count_out != 16'hFFFF)
        forced_count_out <= forced_count_out + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_te_port_arbiter.sv
// Directed bench for te_port_arbiter with a write-first, two-stage BRAM model.
module tb_te_port_arbiter;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr, mem_addr;
  logic [7:0]    wr_data, rd_data, mem_din, mem_dout;
  logic          rd_data_valid, mem_we;

  logic [7:0]    bram [0:32767];
  logic [7:0]    q0, q1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] rdv_tbl, exp_rd_tbl, exp_wr_tbl, exp_v_tbl;

  always #5 clk = ~clk;

  te_port_arbiter #(
    .SCREEN_WIDTH(76), .SCREEN_HEIGHT(256), .READ_LATENCY(2), .MAX_WAIT(4)
  ) dut (
    .pixel_clk_in(clk), .rst_in(rst),
    .wr_valid_in(wr_valid), .wr_addr_in(wr_addr), .wr_data_in(wr_data),
    .wr_ready_out(wr_ready),
    .rd_valid_in(rd_valid), .rd_addr_in(rd_addr), .rd_ready_out(rd_ready),
    .rd_data_out(rd_data), .rd_data_valid_out(rd_data_valid),
    .mem_we_out(mem_we), .mem_addr_out(mem_addr), .mem_din_out(mem_din),
    .mem_dout_in(mem_dout)
  );

  // Write-first BRAM, read latency 2 edges from the registered address.
  always @(posedge clk) begin
    if (mem_we) bram[mem_addr] <= mem_din;
    q0 <= mem_we ? mem_din : bram[mem_addr];
    q1 <= q0;
  end
  assign mem_dout = q1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = 8'h00;
    for (int i = 0; i < 10; i++) bram[i] = 8'h80 + 8'(i);
    bram[19456] = 8'hEE;
    #2;
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_din, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_rvalid", rd_data_valid, 0);
    wr_valid = 1'b1; rd_valid = 1'b1;
    #1;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_ready", rd_ready, 0);
    wr_valid = 1'b0; rd_valid = 1'b0;
    tick; tick;
    rst = 1'b0;

    // lone write
    wr_valid = 1'b1; wr_addr = 15'd100; wr_data = 8'h41;
    #1;
    chk("lw_ready", wr_ready, 1);
    tick;
    wr_valid = 1'b0;
    chk("lw_we", mem_we, 1);
    chk("lw_addr", mem_addr, 100);
    chk("lw_din", mem_din, 8'h41);
    tick;
    chk("lw_we_low", mem_we, 0);
    chk("lw_addr_hold", mem_addr, 100);

    // lone read: valid exactly 3 edges after acceptance
    rd_valid = 1'b1; rd_addr = 15'd100;
    #1;
    chk("lr_ready", rd_ready, 1);
    tick;
    rd_valid = 1'b0;
    chk("lr_addr", mem_addr, 100);
    chk("lr_we", mem_we, 0);
    for (int k = 1; k <= 3; k++) begin
      tick;
      chk("lr_valid", rd_data_valid, (k == 3) ? 1 : 0);
    end
    chk("lr_data", rd_data, 8'h41);
    tick;
    chk("lr_valid_drop", rd_data_valid, 0);

    // write followed immediately by read of same address
    wr_valid = 1'b1; wr_addr = 15'd200; wr_data = 8'h5A;
    tick;
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 15'd200;
    tick;
    rd_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick;
      chk("wr_rd_valid", rd_data_valid, (k == 3) ? 1 : 0);
    end
    chk("wr_rd_data", rd_data, 8'h5A);

    // arbitration: writer always valid; reader drops only in cycle 14
    rdv_tbl    = 16'hBFFF;
    exp_rd_tbl = 16'h0210;
    exp_wr_tbl = 16'hFDEF;
    exp_v_tbl  = 16'h1080;
    for (int c = 0; c < 16; c++) begin
      wr_valid = 1'b1; wr_addr = AW'(300 + c); wr_data = 8'(c);
      rd_valid = rdv_tbl[c]; rd_addr = 15'd100;
      #1;
      chk($sformatf("arb_wr_ready_c%0d", c), wr_ready, exp_wr_tbl[c]);
      chk($sformatf("arb_rd_ready_c%0d", c), rd_ready, exp_rd_tbl[c]);
      tick;
      chk($sformatf("arb_we_c%0d", c), mem_we, exp_wr_tbl[c]);
      chk($sformatf("arb_addr_c%0d", c), mem_addr, exp_rd_tbl[c] ? 100 : 300 + c);
      chk($sformatf("arb_rvalid_c%0d", c), rd_data_valid, exp_v_tbl[c]);
      if (exp_v_tbl[c]) chk($sformatf("arb_rdata_c%0d", c), rd_data, 8'h41);
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    tick; tick; tick;

    // out-of-range write never strobes we
    wr_valid = 1'b1; wr_addr = 15'd19456; wr_data = 8'hFF;
    #1;
    chk("oor_wr_ready", wr_ready, 1);
    tick;
    wr_valid = 1'b0;
    chk("oor_we", mem_we, 0);
    tick;
    chk("oor_we_next", mem_we, 0);

    // out-of-range read returns zero on the normal schedule
    rd_valid = 1'b1; rd_addr = 15'd19456;
    #1;
    chk("oor_rd_ready", rd_ready, 1);
    tick;
    rd_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick;
      chk("oor_rvalid", rd_data_valid, (k == 3) ? 1 : 0);
    end
    chk("oor_rdata", rd_data, 8'h00);

    // back-to-back reads of addresses 0..9
    for (int t = 0; t < 14; t++) begin
      rd_valid = (t < 10); rd_addr = AW'(t);
      tick;
      chk($sformatf("b2b_valid_t%0d", t), rd_data_valid, (t >= 3 && t <= 12) ? 1 : 0);
      if (t >= 3 && t <= 12)
        chk($sformatf("b2b_data_t%0d", t), rd_data, 8'h80 + 8'(t - 3));
    end
    rd_valid = 1'b0;

    // reset one cycle after a read acceptance drops that read
    rd_valid = 1'b1; rd_addr = 15'd100;
    tick;
    rd_valid = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    chk("mid_rst_rdata", rd_data, 0);
    chk("mid_rst_rvalid", rd_data_valid, 0);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_din", mem_din, 0);
    tick;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk($sformatf("post_rst_rvalid_%0d", k), rd_data_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/te_port_arbiter.md
# te_port_arbiter

Shares the single port of the text-editor character BRAM (SCREEN_WIDTH×SCREEN_HEIGHT bytes) between two requesters:
- the terminal controller's grid-write stream (writer);
- a sequential reader, such as a program loader that scans the typed text.

The writer normally has priority. The reader gets a bounded-wait guarantee, so keystroke writes never starve a read.

The block registers all memory-side signals. It also tracks in-flight reads, so each returned byte is tagged valid exactly when it arrives.

## Interface
Parameters:
- SCREEN_WIDTH, 76, characters per row
- SCREEN_HEIGHT, 256, rows
- ADDR_W, $clog2(SCREEN_WIDTH*SCREEN_HEIGHT), address width (derived, not overridden)
- READ_LATENCY, 2, BRAM read latency in clock edges (1..4)
- MAX_WAIT, 4, maximum consecutive cycles a pending reader may be denied (1..15)

Ports:
- pixel_clk_in  input  1  sole clock
- rst_in  input  1  asynchronous, active-high reset
- wr_valid_in  input  1  writer request
- wr_addr_in  input  ADDR_W  write address
- wr_data_in  input  8  character to write
- wr_ready_out  output  1  write accepted this cycle (combinational)
- rd_valid_in  input  1  reader request
- rd_addr_in  input  ADDR_W  read address
- rd_ready_out  output  1  read accepted this cycle (combinational)
- rd_data_out  output  8  returned character
- rd_data_valid_out  output  1  one-cycle strobe, rd_data_out valid
- mem_we_out  output  1  BRAM write enable
- mem_addr_out  output  ADDR_W  BRAM address
- mem_din_out  output  8  BRAM write data
- mem_dout_in  input  8  BRAM read data

## Operation
- A request is accepted in a cycle when its valid and its ready are both high. At most one request is accepted per cycle.
- FSM has two states:
  - WR_PRI (reset state):
    - wr_ready_out = wr_valid_in;
    - rd_ready_out = rd_valid_in & ~wr_valid_in.
  - RD_FORCED:
    - rd_ready_out = rd_valid_in;
    - wr_ready_out = wr_valid_in & ~rd_valid_in.
- Starvation counter wait_cnt (4 bits):
  - increments in any cycle where rd_valid_in=1 and the read is not accepted;
  - clears on read acceptance or when rd_valid_in=0.
- Transitions:
  - WR_PRI→RD_FORCED when wait_cnt reaches MAX_WAIT−1 in a denied cycle, so the read is granted on the next request cycle.
  - RD_FORCED→WR_PRI after one read acceptance, or when rd_valid_in drops.
- On an accepted write, at that edge: mem_we_out←1, mem_addr_out←wr_addr_in, mem_din_out←wr_data_in.
- On an accepted read, at that edge: mem_we_out←0 and mem_addr_out←rd_addr_in. A valid tag enters a shift register of depth READ_LATENCY.
- Cycles with no acceptance: mem_we_out←0; mem_addr_out and mem_din_out hold their values.
- Out-of-range address (≥ SCREEN_WIDTH*SCREEN_HEIGHT):
  - the request is still accepted and consumes the grant;
  - a write is suppressed (mem_we_out stays 0);
  - a read returns 8'h00 with rd_data_valid_out asserted on the normal schedule.
- Reads are fully pipelined: one read per cycle sustains one result per cycle, and results return in order.
- A write to address A followed by a read of A returns the new data; the BRAM is write-first and the arbiter adds no reordering.

## Timing
- Reset values:
  - wr_ready_out and rd_ready_out follow the combinational rules with state WR_PRI;
  - rd_data_out=0, rd_data_valid_out=0, mem_we_out=0, mem_addr_out=0, mem_din_out=0;
  - wait_cnt=0 and all read tags cleared.
- Write latency: mem_we_out is high for exactly one cycle, immediately after the accepting edge.
- Read latency: with accepting edge E0, rd_data_out←mem_dout_in (or 0 for out-of-range) at edge E0+READ_LATENCY+1. rd_data_valid_out is high for that one cycle.
- Worst-case reader wait under continuous writer traffic is MAX_WAIT cycles. The writer then loses exactly one cycle.
- Reset asserted mid-operation clears everything asynchronously. In-flight reads are dropped and produce no rd_data_valid_out after reset release.
- Simultaneous requests:
  - in WR_PRI, the writer wins;
  - in RD_FORCED, the reader wins;
  - the loser holds valid and is not accepted.

## Configuration
- TE_ARB_STATS_EN defined adds three outputs:
  - wr_count_out[15:0]: accepted in-range writes;
  - rd_count_out[15:0]: accepted reads;
  - forced_count_out[15:0]: RD_FORCED grants.
- All three counters are saturating at 16'hFFFF and cleared by rst_in.
- Without TE_ARB_STATS_EN these ports and counters do not exist. Arbitration behaviour is identical in both builds.

## Test plan
- Lone write: wr_valid_in=1, addr=100, data=8'h41 for 1 cycle → wr_ready_out=1; next cycle mem_we_out=1, mem_addr_out=100, mem_din_out=8'h41; mem_we_out=0 the cycle after.
- Lone read, READ_LATENCY=2: rd_addr_in=100 with BRAM model holding 8'h41 → rd_data_valid_out high exactly 3 edges after acceptance, rd_data_out=8'h41.
- Starvation, MAX_WAIT=4: writer valid continuously and reader valid from cycle 0 → reader accepted on cycle 4; writer denied that cycle only; writer resumes cycle 5; no reader wait exceeds 4.
- Back-to-back reads: addresses 0..9 on consecutive cycles with the writer idle → 10 consecutive rd_data_valid_out strobes with data in address order.
- Out-of-range: write to address 19456 (=76×256) → mem_we_out never asserts. Read of 19456 → rd_data_out=8'h00 with valid strobe.
- Reset mid-read: assert rst_in one cycle after a read acceptance → all outputs return to reset values, and no rd_data_valid_out occurs for that read.
